fifo_param: RTL and testbench



---
 rtl/fifo_param_if.sv | 33 +++
 rtl/fifo_param.sv | 98 +++++++++
 tb/tb_fifo_param.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// Handshake and status bundle between a FIFO and its producer/consumer.
// The master modport belongs to the producer/consumer side; the slave modport
// belongs to the FIFO itself.
interface fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  Enable;
    logic                  write_enable;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] FIFO_data_in;
    logic [DATA_WIDTH-1:0] FIFO_data_out;
    logic                  FIFO_valid;
    logic [ADDR_WIDTH:0]   FIFO_count;
    logic                  FIFO_empty;
    logic                  FIFO_full;
    logic                  FIFO_almost_empty;
    logic                  FIFO_almost_full;
    logic                  FIFO_overflow;
    logic                  FIFO_underflow;

    modport master (
        output Enable, write_enable, read_enable, FIFO_data_in,
        input  FIFO_data_out, FIFO_valid, FIFO_count, FIFO_empty, FIFO_full,
               FIFO_almost_empty, FIFO_almost_full, FIFO_overflow, FIFO_underflow
    );

    modport slave (
        input  Enable, write_enable, read_enable, FIFO_data_in,
        output FIFO_data_out, FIFO_valid, FIFO_count, FIFO_empty, FIFO_full,
               FIFO_almost_empty, FIFO_almost_full, FIFO_overflow, FIFO_underflow
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with registered read data, explicit occupancy
// count, almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Full/empty are decoded from the occupancy counter, never from the pointers.
module fifo_param #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic         clk,
    input  logic         Reset,
    fifo_param_if.slave  fifo_bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_TH     = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_TH     = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_empty;
    logic w_full;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_ovf_evt;
    logic w_udf_evt;

    // Status decodes of the registered count plus accept/error qualification.
    // A write into a full FIFO is allowed when a read frees a slot on the same edge.
    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == DEPTH_CNT);
        w_rd_acc  = fifo_bus.Enable & fifo_bus.read_enable & ~w_empty;
        w_wr_acc  = fifo_bus.Enable & fifo_bus.write_enable & (~w_full | w_rd_acc);
        w_ovf_evt = fifo_bus.Enable & fifo_bus.write_enable & w_full & ~w_rd_acc;
        w_udf_evt = fifo_bus.Enable & fifo_bus.read_enable & w_empty;
    end

    // Storage array; deliberately not cleared by reset, but a write on the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!Reset && w_wr_acc) begin
            r_mem[r_wr_ptr] <= fifo_bus.FIFO_data_in;
        end
    end

    // Pointers, occupancy, read data register and sticky error flags.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
            if (w_udf_evt) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Drive the bundle outputs.
    always_comb begin
        fifo_bus.FIFO_data_out     = r_data_out;
        fifo_bus.FIFO_valid        = r_valid;
        fifo_bus.FIFO_count        = r_count;
        fifo_bus.FIFO_empty        = w_empty;
        fifo_bus.FIFO_full         = w_full;
        fifo_bus.FIFO_almost_empty = (r_count <= AE_TH);
        fifo_bus.FIFO_almost_full  = (r_count >= AF_TH);
        fifo_bus.FIFO_overflow     = r_overflow;
        fifo_bus.FIFO_underflow    = r_underflow;
    end
endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed scenarios followed by random traffic, all
// checked against a queue-based reference model after every clock edge.
module tb_fifo_param;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF_TH = 6;
    localparam int AE_TH = 2;

    logic clk;
    logic rst;

    fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_if ();

    fifo_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)
    ) dut (
        .clk(clk),
        .Reset(rst),
        .fifo_bus(u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout;
    bit            m_valid;
    bit            m_ovf;
    bit            m_udf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit en, input bit we, input bit re,
                              input logic [DW-1:0] din);
        int  sz;
        bit  rd;
        bit  wr;
        sz = m_q.size();
        if (r) begin
            m_q.delete();
            m_dout  = '0;
            m_valid = 0;
            m_ovf   = 0;
            m_udf   = 0;
        end else if (!en) begin
            m_valid = 0;
        end else begin
            rd = re && (sz > 0);
            wr = we && ((sz < DEPTH) || rd);
            if (we && sz == DEPTH && !rd) m_ovf = 1;
            if (re && sz == 0) m_udf = 1;
            if (rd) m_dout = m_q.pop_front();
            if (wr) m_q.push_back(din);
            m_valid = rd;
        end
    endtask

    task automatic check_all();
        int sz;
        sz = m_q.size();
        chk("count",    32'(u_if.FIFO_count),        32'(sz));
        chk("empty",    32'(u_if.FIFO_empty),        32'(sz == 0));
        chk("full",     32'(u_if.FIFO_full),         32'(sz == DEPTH));
        chk("alm_empty",32'(u_if.FIFO_almost_empty), 32'(sz <= AE_TH));
        chk("alm_full", 32'(u_if.FIFO_almost_full),  32'(sz >= AF_TH));
        chk("overflow", 32'(u_if.FIFO_overflow),     32'(m_ovf));
        chk("underflow",32'(u_if.FIFO_underflow),    32'(m_udf));
        chk("valid",    32'(u_if.FIFO_valid),        32'(m_valid));
        chk("data_out", 32'(u_if.FIFO_data_out),     32'(m_dout));
    endtask

    // One clock: drive inputs away from the edge, advance model at the edge, check #1 later.
    task automatic cyc(input bit r, input bit en, input bit we, input bit re,
                       input logic [DW-1:0] din);
        rst                 = r;
        u_if.Enable         = en;
        u_if.write_enable   = we;
        u_if.read_enable    = re;
        u_if.FIFO_data_in   = din;
        @(posedge clk);
        model_edge(r, en, we, re, din);
        #1;
        check_all();
    endtask

    initial begin
        logic [DW-1:0] hold_dout;
        rst = 1'b1;
        u_if.Enable = 0; u_if.write_enable = 0; u_if.read_enable = 0; u_if.FIFO_data_in = '0;
        m_dout = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
        #2;

        // Reset then fill with 0x01..0x08, then drain in order
        cyc(1, 0, 0, 0, 8'h00);
        chk("rst_empty", 32'(u_if.FIFO_empty), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 1, 0, DW'(i));
            chk("fill_cnt", 32'(u_if.FIFO_count), 32'(i));
        end
        chk("full_after_8", 32'(u_if.FIFO_full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 0, 1, 8'h00);
            chk("drain_data", 32'(u_if.FIFO_data_out), 32'(i));
        end
        chk("empty_after_drain", 32'(u_if.FIFO_empty), 32'd1);

        // Overflow, then write+read together while full
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, DW'(8'h30 + i));
        cyc(0, 1, 1, 0, 8'hAA);
        chk("ovf_set", 32'(u_if.FIFO_overflow), 32'd1);
        cyc(0, 1, 1, 1, 8'hBB);
        chk("full_rw_data", 32'(u_if.FIFO_data_out), 32'h30);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1, 8'h00);
        chk("bb_last", 32'(u_if.FIFO_data_out), 32'hBB);

        // Read and write on the same edge into an empty FIFO
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 1, 8'h55);
        chk("udf_same_edge", 32'(u_if.FIFO_underflow), 32'd1);
        cyc(0, 1, 0, 1, 8'h00);
        chk("read_55", 32'(u_if.FIFO_data_out), 32'h55);

        // Pointer wrap with occupancy held at 3
        cyc(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, DW'(8'h10 + i));
        for (int i = 3; i < 20; i++) cyc(0, 1, 1, 1, DW'(8'h10 + i));
        chk("wrap_cnt", 32'(u_if.FIFO_count), 32'd3);

        // Enable low at count 4 with both requests asserted
        cyc(0, 1, 1, 0, 8'h24);
        cyc(0, 1, 0, 1, 8'h00);
        cyc(0, 1, 1, 0, 8'h25);
        hold_dout = u_if.FIFO_data_out;
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 8'hEE);
        chk("dis_cnt", 32'(u_if.FIFO_count), 32'd4);
        chk("dis_dout", 32'(u_if.FIFO_data_out), 32'(hold_dout));

        // Reset with a write on the same edge at 5 entries
        cyc(0, 1, 1, 0, 8'h26);
        cyc(0, 1, 1, 1, 8'h27);
        cyc(1, 1, 1, 0, 8'h99);
        chk("rst_wr_cnt", 32'(u_if.FIFO_count), 32'd0);
        cyc(0, 1, 0, 1, 8'h00);
        chk("post_rst_udf", 32'(u_if.FIFO_underflow), 32'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1),
                DW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
